// File: rtl/flash_arb_pkg.sv
// Shared types for the flash read arbiter: FSM states, port count and port index type.
package flash_arb_pkg;

    localparam int FLASH_ARB_PORTS = 2;

    typedef logic [0:0] flash_arb_port_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } flash_arb_state_t;

endpackage

// File: rtl/flash_arb_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, otherwise the port that was not
// granted last time wins.
module flash_arb_rr_pick
    import flash_arb_pkg::*;
(
    input  logic [FLASH_ARB_PORTS-1:0] req_valid,
    input  logic                       last_grant,
    output logic [FLASH_ARB_PORTS-1:0] grant_onehot,
    output logic                       grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        case (req_valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
        grant_onehot = (req_valid == '0) ? '0 : (FLASH_ARB_PORTS'(1) << grant_idx);
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Arbitrates single 32-bit reads from two requesters onto one SPI flash read controller.
// Optional WAIT-state watchdog is compiled in with FLASH_ARB_TIMEOUT_EN.
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [FLASH_ARB_PORTS-1:0]                req_valid,
    input  logic [FLASH_ARB_PORTS-1:0][ADDR_WIDTH-1:0] req_addr,
    output logic [FLASH_ARB_PORTS-1:0]                req_ready,
    output logic [FLASH_ARB_PORTS-1:0]                resp_valid,
    output logic [DATA_WIDTH-1:0]                     resp_data,
    output logic                                      resp_err,
    output logic                                      cmd_valid,
    input  logic                                      cmd_ready,
    output logic [ADDR_WIDTH-1:0]                     cmd_addr,
    output logic                                      cmd_abort,
    input  logic                                      rsp_valid,
    input  logic [DATA_WIDTH-1:0]                     rsp_data
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    flash_arb_state_t             state_q, state_d;
    flash_arb_port_t              grant_q;
    flash_arb_port_t              last_grant_q;
    logic [ADDR_WIDTH-1:0]        cmd_addr_q;
    logic [DATA_WIDTH-1:0]        resp_data_q;
    logic [FLASH_ARB_PORTS-1:0]   pick_onehot;
    logic                         pick_idx;
    logic                         timeout;

    flash_arb_rr_pick u_pick (
        .req_valid    (req_valid),
        .last_grant   (last_grant_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx)
    );

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             resp_err_q;

    // A response arriving on the timeout cycle wins over the abort.
    assign timeout = (state_q == ST_WAIT) && !rsp_valid &&
                     (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside WAIT so it starts from zero on every WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q != ST_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_q <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            if (rsp_valid) begin
                resp_err_q <= 1'b0;
            end else if (timeout) begin
                resp_err_q <= 1'b1;
            end
        end
    end

    assign resp_err = resp_err_q;
`else
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (|req_valid) state_d = ST_ISSUE;
            ST_ISSUE: if (cmd_ready) state_d = ST_WAIT;
            ST_WAIT:  if (rsp_valid || timeout) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= 1'b1;
            cmd_addr_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && |req_valid) begin
                grant_q    <= pick_idx;
                cmd_addr_q <= req_addr[pick_idx];
            end
            if (state_q == ST_WAIT) begin
                if (rsp_valid) begin
                    resp_data_q <= rsp_data;
                end else if (timeout) begin
                    resp_data_q <= '0;
                end
            end
            if (state_q == ST_RESP) begin
                last_grant_q <= grant_q;
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE) ? pick_onehot : '0;
    assign cmd_valid  = (state_q == ST_ISSUE);
    assign cmd_addr   = cmd_addr_q;
    assign cmd_abort  = timeout;
    assign resp_valid = (state_q == ST_RESP) ? (FLASH_ARB_PORTS'(1) << grant_q) : '0;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: directed reads against a transaction-level model.
// Timeout scenarios run when FLASH_ARB_TIMEOUT_EN is defined.
module tb_flash_read_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef FLASH_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [1:0]          req_valid;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0]          req_ready;
    logic [1:0]          resp_valid;
    logic [DW-1:0]       resp_data;
    logic                resp_err;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [AW-1:0]       cmd_addr;
    logic                cmd_abort;
    logic                rsp_valid;
    logic [DW-1:0]       rsp_data;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    flash_read_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_abort  (cmd_abort),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase of the single outstanding read plus its latched fields.
    // Phases: 0 no read, 1 command offered, 2 awaiting data, 3 returning data.
    int          m_phase;
    bit          m_last;
    bit          m_grant;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit          m_err;
    int          m_wait;

    function automatic bit winner();
        if (req_valid == 2'b11) return !m_last;
        return req_valid[1];
    endfunction

    function automatic logic [1:0] exp_ready();
        if (m_phase != 0 || req_valid == 2'b00) return 2'b00;
        return winner() ? 2'b10 : 2'b01;
    endfunction

    function automatic bit exp_abort();
        return TO_EN && m_phase == 2 && !rsp_valid && m_wait == TO - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_last  <= 1'b1;
            m_grant <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_err   <= 1'b0;
            m_wait  <= 0;
        end else if (m_phase == 0) begin
            if (req_valid != 2'b00) begin
                m_grant <= winner();
                m_addr  <= req_addr[winner()];
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (cmd_ready) begin
                m_phase <= 2;
                m_wait  <= 0;
            end
        end else if (m_phase == 2) begin
            if (rsp_valid) begin
                m_data  <= rsp_data;
                m_err   <= 1'b0;
                m_phase <= 3;
            end else if (exp_abort()) begin
                m_data  <= '0;
                m_err   <= 1'b1;
                m_phase <= 3;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else begin
            m_last  <= m_grant;
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", req_ready, exp_ready());
            check("cmd_valid", cmd_valid, m_phase == 1);
            check("cmd_addr", cmd_addr, m_addr);
            check("resp_valid", resp_valid, (m_phase == 3) ? (m_grant ? 2'b10 : 2'b01) : 2'b00);
            check("resp_data", resp_data, m_data);
            check("resp_err", resp_err, m_err);
            check("cmd_abort", cmd_abort, exp_abort());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(output int port);
        port = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                port = req_ready[1] ? 1 : 0;
                break;
            end
        end
        checks++;
        if (port < 0) begin
            errors++;
            $display("FAIL accept_wait: no req_ready within 40 cycles at %0t", $time);
        end
    endtask

    task automatic wait_cmd();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL cmd_wait: no command handshake within 40 cycles at %0t", $time);
        end
    endtask

    // Full read: accept, command, data returned dly cycles after the command handshake.
    task automatic serve(input int dly, input logic [DW-1:0] data, input bit drop,
                         output int port);
        wait_accept(port);
        tick();
        if (drop && port >= 0) req_valid[port] = 1'b0;
        wait_cmd();
        repeat (dly) tick();
        rsp_valid = 1'b1;
        rsp_data  = data;
        tick();
        rsp_valid = 1'b0;
        rsp_data  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int p;
        int g[4];
        int exp_order[4];
        int n;
        exp_order = '{0, 1, 0, 1};
        req_valid = '0;
        req_addr  = '0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;

        // Reset state
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ctrl", {req_ready, resp_valid, resp_err, cmd_valid, cmd_abort}, 7'd0);
        check("rst_cmd_addr", cmd_addr, 24'h0);
        check("rst_resp_data", resp_data, 32'h0);
        tick();
        rst_n = 1'b1;

        // Single port-0 read
        req_addr[0] = 24'h400000;
        req_valid   = 2'b01;
        cmd_ready   = 1'b1;
        wait_accept(p);
        check("t1_grant", p, 0);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("t1_cmd_valid", cmd_valid, 1'b1);
        check("t1_cmd_addr", cmd_addr, 24'h400000);
        repeat (3) tick();
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEADBEEF;
        tick();
        rsp_valid = 1'b0;
        rsp_data  = '0;
        @(negedge clk);
        check("t1_resp_valid", resp_valid, 2'b01);
        check("t1_resp_data", resp_data, 32'hDEADBEEF);
        check("t1_resp_err", resp_err, 1'b0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid != 2'b00) n++;
        end
        check("t1_extra_resp", n, 0);
        tick();

        // Contention from reset
        do_reset();
        req_addr[0] = 24'h400010;
        req_addr[1] = 24'h001000;
        req_valid   = 2'b11;
        for (int i = 0; i < 4; i++) begin
            serve(1, 32'hA000_0000 + i, 1'b0, g[i]);
            check("t2_grant_order", g[i], exp_order[i]);
            if (i > 0) check("t2_no_repeat", g[i] == g[i-1], 1'b0);
        end
        req_valid = 2'b00;
        repeat (2) tick();

        // Backpressure: command held for 5 cycles while port 1 also asks
        cmd_ready   = 1'b0;
        req_addr[0] = 24'h400020;
        req_addr[1] = 24'h123456;
        req_valid   = 2'b01;
        wait_accept(p);
        check("t3_grant", p, 0);
        tick();
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_cmd_valid", cmd_valid, 1'b1);
            check("t3_cmd_addr", cmd_addr, 24'h400020);
            check("t3_no_ready", req_ready, 2'b00);
            tick();
        end
        cmd_ready = 1'b1;
        wait_cmd();
        tick();
        rsp_valid = 1'b1;
        rsp_data  = 32'h1111_2222;
        tick();
        rsp_valid = 1'b0;
        serve(2, 32'h5555AAAA, 1'b1, p);
        check("t3_port1_served", p, 1);
        tick();

        // Stray response in IDLE
        tick();
        rsp_valid = 1'b1;
        rsp_data  = 32'hBAD0BAD0;
        tick();
        rsp_valid = 1'b0;
        rsp_data  = '0;
        repeat (4) begin
            @(negedge clk);
            check("t4_no_resp", resp_valid, 2'b00);
            check("t4_data_kept", resp_data, 32'h5555AAAA);
            tick();
        end

        // Long wait: watchdog behaviour
        req_addr[0] = 24'h400030;
        req_valid   = 2'b01;
        wait_accept(p);
        tick();
        req_valid = 2'b00;
        wait_cmd();
`ifdef FLASH_ARB_TIMEOUT_EN
        begin
            int abort_at = -1;
            int resp_at  = -1;
            logic rerr = 1'b0;
            logic [DW-1:0] rdat = '1;
            for (int i = 1; i <= 10; i++) begin
                tick();
                @(negedge clk);
                if (cmd_abort && abort_at < 0) abort_at = i;
                if (resp_valid == 2'b01 && resp_at < 0) begin
                    resp_at = i;
                    rerr = resp_err;
                    rdat = resp_data;
                end
            end
            check("t5_abort_cycle", abort_at, 8);
            check("t5_resp_cycle", resp_at, 9);
            check("t5_resp_err", rerr, 1'b1);
            check("t5_resp_data", rdat, 32'h0);
        end
        tick();
        req_valid = 2'b01;
        wait_accept(p);
        tick();
        req_valid = 2'b00;
        wait_cmd();
        repeat (8) tick();
        rsp_valid = 1'b1;
        rsp_data  = 32'hCAFEF00D;
        @(negedge clk);
        check("t5b_no_abort", cmd_abort, 1'b0);
        tick();
        rsp_valid = 1'b0;
        rsp_data  = '0;
        @(negedge clk);
        check("t5b_resp_valid", resp_valid, 2'b01);
        check("t5b_resp_err", resp_err, 1'b0);
        check("t5b_resp_data", resp_data, 32'hCAFEF00D);
`else
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            if (cmd_abort || resp_valid != 2'b00) n++;
        end
        check("t5_no_abort_no_resp", n, 0);
        tick();
        rsp_valid = 1'b1;
        rsp_data  = 32'hCAFEF00D;
        tick();
        rsp_valid = 1'b0;
        rsp_data  = '0;
        @(negedge clk);
        check("t5_late_resp_valid", resp_valid, 2'b01);
        check("t5_late_resp_data", resp_data, 32'hCAFEF00D);
        check("t5_late_resp_err", resp_err, 1'b0);
`endif
        tick();

        // Async reset while waiting on the flash
        req_addr[0] = 24'h400040;
        req_valid   = 2'b01;
        wait_accept(p);
        tick();
        req_valid = 2'b00;
        wait_cmd();
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {req_ready, resp_valid, resp_err, cmd_valid, cmd_abort}, 7'd0);
        check("t6_rst_cmd_addr", cmd_addr, 24'h0);
        check("t6_rst_resp_data", resp_data, 32'h0);
        tick();
        tick();
        rst_n       = 1'b1;
        req_addr[1] = 24'h000200;
        req_valid   = 2'b11;
        wait_accept(p);
        check("t6_first_grant", p, 0);
        tick();
        req_valid = 2'b00;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
